// File: rtl/demux_stream_router.sv
// Registered 1:N stream router. Each output owns a one-entry holding slot, so a
// stalled consumer only back-pressures beats addressed to its own slot.

module demux_stream_slot #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  ld_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  accept_o
);

  logic                  valid_d, valid_q;
  logic [DATA_WIDTH-1:0] data_d,  data_q;

  // A load wins over a drain, so drain-and-refill in one cycle leaves no bubble.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ld_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign accept_o = !valid_q || ready_i;

endmodule

module demux_stream_router #(
  parameter int NUM_ELEM   = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8,
  localparam int SEL_W     = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1
) (
  input  logic                           clk_i,
  input  logic                           arst_i,
  input  logic [DATA_WIDTH-1:0]          in_data_i,
  input  logic [SEL_W-1:0]               in_sel_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  output logic [NUM_ELEM*DATA_WIDTH-1:0] out_data_o,
  output logic [NUM_ELEM-1:0]            out_valid_o,
  input  logic [NUM_ELEM-1:0]            out_ready_i,
  output logic [CNT_WIDTH-1:0]           drop_cnt_o
);

  logic [NUM_ELEM-1:0]                 slot_acc;
  logic [NUM_ELEM-1:0]                 slot_ld;
  logic [NUM_ELEM-1:0][DATA_WIDTH-1:0] slot_data;
  logic                                sel_ok;
  logic                                tgt_rdy;
  logic                                xfer;
  logic                                drop;
  logic [CNT_WIDTH-1:0]                cnt_d, cnt_q;

  // Out-of-range selects are always accepted (and dropped), hence tgt_rdy defaults high.
  always_comb begin
    sel_ok  = 1'b0;
    tgt_rdy = 1'b1;
    for (int k = 0; k < NUM_ELEM; k++) begin
      if (in_sel_i == SEL_W'(k)) begin
        sel_ok  = 1'b1;
        tgt_rdy = slot_acc[k];
      end
    end
  end

  assign in_ready_o = !arst_i && tgt_rdy;
  // Gating with in_valid_i first keeps X on sel/data out of the slot enables.
  assign xfer       = in_valid_i && in_ready_o;
  assign drop       = xfer && !sel_ok;

  genvar g;
  generate
    for (g = 0; g < NUM_ELEM; g++) begin : g_slot
      assign slot_ld[g] = xfer && (in_sel_i == SEL_W'(g));

      demux_stream_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
        .clk_i    (clk_i),
        .arst_i   (arst_i),
        .ld_i     (slot_ld[g]),
        .data_i   (in_data_i),
        .ready_i  (out_ready_i[g]),
        .valid_o  (out_valid_o[g]),
        .data_o   (slot_data[g]),
        .accept_o (slot_acc[g])
      );
    end
  endgenerate

  assign out_data_o = slot_data;

  always_comb begin
    cnt_d = cnt_q;
    if (drop && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign drop_cnt_o = cnt_q;

endmodule

// File: tb/tb_demux_stream_router.sv
// Three router configurations share one input stream; a slot-level model checks
// every output each cycle, with literal spot checks pinning the directed cases.

module tb_demux_stream_router;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [1:0] sel;
  logic       vld;
  logic [3:0] rdy;

  logic        ir_a, ir_b, ir_c;
  logic [31:0] od_a;
  logic [23:0] od_b, od_c;
  logic [3:0]  ov_a;
  logic [2:0]  ov_b, ov_c;
  logic [7:0]  cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux_stream_router #(.NUM_ELEM(4), .DATA_WIDTH(8), .CNT_WIDTH(8)) u_a (
    .clk_i(clk), .arst_i(rst), .in_data_i(din), .in_sel_i(sel), .in_valid_i(vld),
    .in_ready_o(ir_a), .out_data_o(od_a), .out_valid_o(ov_a), .out_ready_i(rdy),
    .drop_cnt_o(cnt_a));

  demux_stream_router #(.NUM_ELEM(3), .DATA_WIDTH(8), .CNT_WIDTH(8)) u_b (
    .clk_i(clk), .arst_i(rst), .in_data_i(din), .in_sel_i(sel), .in_valid_i(vld),
    .in_ready_o(ir_b), .out_data_o(od_b), .out_valid_o(ov_b), .out_ready_i(rdy[2:0]),
    .drop_cnt_o(cnt_b));

  demux_stream_router #(.NUM_ELEM(3), .DATA_WIDTH(8), .CNT_WIDTH(2)) u_c (
    .clk_i(clk), .arst_i(rst), .in_data_i(din), .in_sel_i(sel), .in_valid_i(vld),
    .in_ready_o(ir_c), .out_data_o(od_c), .out_valid_o(ov_c), .out_ready_i(rdy[2:0]),
    .drop_cnt_o(cnt_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per instance, the contents of each one-entry slot and the drop count.
  int         ne[3] = '{4, 3, 3};
  int         cm[3] = '{255, 255, 3};
  bit         mv[3][4];
  logic [7:0] md[3][4];
  int         mc[3];
  bit         st_v[3][4];
  logic [7:0] st_d[3][4];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [31:0] gov, god, gir, gcnt, eov, eod;
      bit er;
      int s;
      case (i)
        0:       begin gov = 32'(ov_a); god = od_a;       gir = 32'(ir_a); gcnt = 32'(cnt_a); end
        1:       begin gov = 32'(ov_b); god = 32'(od_b);  gir = 32'(ir_b); gcnt = 32'(cnt_b); end
        default: begin gov = 32'(ov_c); god = 32'(od_c);  gir = 32'(ir_c); gcnt = 32'(cnt_c); end
      endcase
      if (rst) begin
        chk($sformatf("rst_valid[%0d]", i), gov, 32'd0);
        chk($sformatf("rst_data[%0d]", i), god, 32'd0);
        chk($sformatf("rst_cnt[%0d]", i), gcnt, 32'd0);
        chk($sformatf("rst_ready[%0d]", i), gir, 32'd0);
        mc[i] = 0;
        for (int k = 0; k < 4; k++) begin
          mv[i][k] = 1'b0; md[i][k] = 8'h00; st_v[i][k] = 1'b0;
        end
      end else begin
        s  = int'(sel);
        er = (s < ne[i]) ? (!mv[i][s] || rdy[s]) : 1'b1;
        eov = '0; eod = '0;
        for (int k = 0; k < ne[i]; k++) begin
          eov[k]       = mv[i][k];
          eod[k*8 +: 8] = md[i][k];
        end
        chk($sformatf("ready[%0d]", i), gir, 32'(er));
        chk($sformatf("valid[%0d]", i), gov, eov);
        chk($sformatf("data[%0d]", i), god, eod);
        chk($sformatf("drops[%0d]", i), gcnt, 32'(mc[i]));
        for (int k = 0; k < ne[i]; k++) begin
          if (st_v[i][k]) begin
            chk($sformatf("stall_valid[%0d][%0d]", i, k), 32'(gov[k]), 32'd1);
            chk($sformatf("stall_data[%0d][%0d]", i, k), 32'(god[k*8 +: 8]), 32'(st_d[i][k]));
          end
          st_v[i][k] = gov[k] && !rdy[k];
          st_d[i][k] = god[k*8 +: 8];
        end
        for (int k = 0; k < ne[i]; k++) begin
          if (vld && er && s == k) begin
            mv[i][k] = 1'b1; md[i][k] = din;
          end else if (mv[i][k] && rdy[k]) begin
            mv[i][k] = 1'b0;
          end
        end
        if (vld && er && s >= ne[i] && mc[i] < cm[i]) mc[i]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; sel = 2'd0; din = 8'h00; rdy = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_ready", 32'(ir_a), 32'd0);
    chk("init_valid", 32'(ov_a), 32'd0);
    rst = 1'b0;

    // Single route, then a second beat held until the consumer drains.
    sel = 2'd2; din = 8'hA5; vld = 1'b1;
    #3 chk("route_ready", 32'(ir_a), 32'd1);
    step(); din = 8'h5A;
    #3 chk("route_valid", 32'(ov_a), 32'b0100);
    chk("route_data", 32'(od_a[23:16]), 32'hA5);
    chk("route_hold", 32'(ir_a), 32'd0);
    step();
    #3 chk("route_held", 32'(od_a[23:16]), 32'hA5);
    step(); rdy = 4'b0100;
    #3 chk("route_reopen", 32'(ir_a), 32'd1);
    step(); vld = 1'b0; rdy = 4'b0000;
    #3 chk("route_next_v", 32'(ov_a), 32'b0100);
    chk("route_next_d", 32'(od_a[23:16]), 32'h5A);

    // Stalled slot 1 must not block traffic to slot 3.
    step(); sel = 2'd1; din = 8'h77; vld = 1'b1; rdy = 4'b0100;
    step(); sel = 2'd3; din = 8'h10; rdy = 4'b1000;
    #3 chk("nb_v0", 32'(ov_a), 32'b0010);
    step(); din = 8'h11;
    #3 chk("nb_v1", 32'(ov_a), 32'b1010);
    chk("nb_d3a", 32'(od_a[31:24]), 32'h10);
    chk("nb_d1a", 32'(od_a[15:8]), 32'h77);
    step(); vld = 1'b0;
    #3 chk("nb_d3b", 32'(od_a[31:24]), 32'h11);
    chk("nb_d1b", 32'(od_a[15:8]), 32'h77);
    step();
    #3 chk("nb_v2", 32'(ov_a), 32'b0010);

    // Asynchronous reset mid-cycle with slots 0 and 2 full.
    step(); sel = 2'd0; din = 8'hC0; vld = 1'b1; rdy = 4'b0000;
    step(); sel = 2'd2; din = 8'hC2;
    step(); vld = 1'b0;
    #1 chk("pre_rst_v", 32'(ov_a), 32'b0111);
    rst = 1'b1;
    #1 chk("async_v", 32'(ov_a), 32'd0);
    chk("async_cnt", 32'(cnt_a), 32'd0);
    chk("async_rdy", 32'(ir_a), 32'd0);
    step(); step(); rst = 1'b0;

    // Back-to-back throughput into slot 0.
    rdy = 4'b0001; sel = 2'd0; vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din = 8'(i);
      #3 chk("tp_ready", 32'(ir_a), 32'd1);
      chk("tp_valid", 32'(ov_a[0]), 32'(i > 0));
      if (i > 0) chk("tp_data", 32'(od_a[7:0]), 32'(i - 1));
      step();
    end
    vld = 1'b0;
    #3 chk("tp_last", 32'(od_a[7:0]), 32'd15);

    // Drops on the 3-output instances; the 2-bit counter saturates.
    step(); rst = 1'b1;
    step(); step(); rst = 1'b0;
    rdy = 4'b1111; sel = 2'd3; vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'($urandom);
      #3 chk("drop_rdy_b", 32'(ir_b), 32'd1);
      chk("drop_rdy_c", 32'(ir_c), 32'd1);
      chk("drop_valid_b", 32'(ov_b), 32'd0);
      step();
    end
    vld = 1'b0;
    #3 chk("drop5_b", 32'(cnt_b), 32'd5);
    chk("drop5_c", 32'(cnt_c), 32'd3);
    vld = 1'b1;
    step(); vld = 1'b0;
    #3 chk("drop6_b", 32'(cnt_b), 32'd6);
    chk("drop6_c", 32'(cnt_c), 32'd3);

    // Random stress with occasional resets; the model checks every cycle.
    for (int n = 0; n < 10000; n++) begin
      vld = ($urandom % 4) != 0;
      sel = 2'($urandom);
      din = 8'($urandom);
      rdy = 4'($urandom);
      rst = ($urandom % 500) == 0;
      step();
    end
    rst = 1'b0; vld = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/demux_stream_router.md
Name: demux_stream_router

Overview:
- Registered 1:N stream router with valid/ready handshake.
- Takes one input stream tagged with a destination select and delivers each beat to exactly one of NUM_ELEM output streams.
- Each output has a one-entry holding register, so a stalled output never blocks beats bound for other outputs.
- Sits downstream of the stream source. It is the handshaked, buffered counterpart of the combinational one-hot demux: it consumes the same select/data pair and adds flow control.

Parameters:
- NUM_ELEM, 4, number of output streams; legal range >= 2, need not be a power of two.
- DATA_WIDTH, 8, payload width in bits.
- CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk_i  input  1  clock, rising edge.
- arst_i  input  1  asynchronous active-high reset.
- in_data_i  input  DATA_WIDTH  input payload.
- in_sel_i  input  $clog2(NUM_ELEM)  destination index.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  router can accept the current input beat.
- out_data_o  output  NUM_ELEM*DATA_WIDTH  flattened output payloads; output k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- out_valid_o  output  NUM_ELEM  per-output valid.
- out_ready_i  input  NUM_ELEM  per-output ready from consumers.
- drop_cnt_o  output  CNT_WIDTH  count of beats dropped for out-of-range select.

Behaviour:
- Reset: arst_i high asynchronously clears out_valid_o to all 0, out_data_o to all 0 and drop_cnt_o to 0. While arst_i is high, in_ready_o is 0. The first transfer is possible on the first rising edge after deassertion.
- Slot state per output k: EMPTY (out_valid_o[k]=0) or FULL (out_valid_o[k]=1). out_data_o for slot k is driven directly from its register.
- Input acceptance:
  - in_sel_i < NUM_ELEM: in_ready_o = !out_valid_o[in_sel_i] || out_ready_i[in_sel_i].
  - in_sel_i >= NUM_ELEM: in_ready_o = 1; the beat is dropped.
  - in_ready_o is combinational from in_sel_i, the slot state and out_ready_i. It does not depend on in_valid_i.
- Input transfer: in_valid_i && in_ready_o at a rising edge.
- Output transfer on k: out_valid_o[k] && out_ready_i[k] at a rising edge.
- Slot k next state:
  - Input transfer with sel=k → FULL, register loads in_data_i. This covers the simultaneous output-drain and reload case: no bubble, the new data appears the next cycle.
  - Otherwise, output transfer on k → EMPTY; the data register holds its old value.
  - Otherwise → unchanged.
- Latency: a beat accepted at edge N is visible on out_valid_o/out_data_o after edge N. Throughput is 1 beat/cycle to a single output whose consumer holds ready high.
- Stability: while out_valid_o[k]=1 and out_ready_i[k]=0, out_data_o slice k and out_valid_o[k] must not change.
- Ordering: beats to the same output are delivered in acceptance order. There is no ordering guarantee across different outputs.
- Drops: an input transfer with in_sel_i >= NUM_ELEM increments drop_cnt_o by 1. The counter saturates at 2^CNT_WIDTH-1 and does not wrap. No output slot changes on a drop.
- in_data_i and in_sel_i are ignored when in_valid_i=0. Input X values on those ports must not propagate when in_valid_i=0.
- Reset mid-operation: all FULL slots are discarded with no output handshake. Beats in flight are lost; this is intended.

Test Plan:
- Reset and idle: assert arst_i asynchronously mid-cycle with slots 0 and 2 FULL → out_valid_o=4'b0000 and drop_cnt_o=0 immediately; in_ready_o=0 until release.
- Single route: sel=2, data=8'hA5, valid for 1 cycle, all out_ready_i=0 → next cycle out_valid_o=4'b0100 and slice 2=8'hA5. A second beat to sel=2 sees in_ready_o=0 and is held. Raising out_ready_i[2] gives in_ready_o=1; the second beat follows with no bubble.
- Non-blocking: slot 1 FULL with out_ready_i[1]=0; stream beats 8'h10, 8'h11 to sel=3 with out_ready_i[3]=1 → both delivered on consecutive cycles; slot 1 holds its data unchanged throughout.
- Back-to-back throughput: 16 beats with sel=0 and data 0..15, out_ready_i[0]=1 constantly → in_ready_o stays 1; the output shows 0..15 on 16 consecutive cycles starting one cycle after the first accept.
- Drop handling: NUM_ELEM=3, sel=3, valid for 5 cycles → in_ready_o=1, no out_valid_o change, drop_cnt_o=5. With CNT_WIDTH=2, 6 drops → drop_cnt_o=3 (saturated).
- Random stress: random valid, sel and per-output ready over 10k cycles against a scoreboard with one queue per output → no loss, duplication or reordering; stability assertion holds on every stalled cycle.
